// File: rtl/svo_defines.sv
// Shared constants for the source scheduler: source IDs, FSM encoding and
// the watchdog counter width helper.
package svo_defines;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } sched_state_e;

  // Counter only has to reach limit-1, so clog2(limit) bits are enough.
  function automatic int stall_cnt_w(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

  localparam int STALL_LIMIT_DEF = 1024;
  localparam int STALL_CNT_W_DEF = stall_cnt_w(STALL_LIMIT_DEF);

endpackage

// File: rtl/svo_src_sched_if.sv
// Pixel AXI-stream bundle (tvalid/tready/tdata/tuser) with source/sink views.
interface svo_src_sched_if #(
  parameter int W = 12
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tuser;

  modport master (output tvalid, tdata, tuser, input tready);
  modport slave  (input tvalid, tdata, tuser, output tready);
endinterface

// File: rtl/svo_axis_reg.sv
// Single-entry registered AXI-stream slice; one cycle latency, holds the
// beat stable while the sink back-pressures.
module svo_axis_reg #(
  parameter int DATA_W = 12,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [USER_W-1:0] s_user,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [USER_W-1:0] m_user
);

  assign s_ready = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_user  <= '0;
    end else if (s_ready) begin
      m_valid <= s_valid;
      if (s_valid) begin
        m_data <= s_data;
        m_user <= s_user;
      end
    end
  end

endmodule

// File: rtl/svo_src_sched.sv
// Frame-synchronous A/B pixel source scheduler: switches only on SOF pairs,
// parks the idle source at its SOF, and falls back when the active one starves.
module svo_src_sched
  import svo_defines::*;
#(
  parameter int SVO_BITS_PER_PIXEL = 12,
  parameter int STALL_LIMIT        = 1024,
  parameter bit DEFAULT_SRC        = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sel,
  input  logic             stall_clear,
  svo_src_sched_if.slave   a_axis,
  svo_src_sched_if.slave   b_axis,
  svo_src_sched_if.master  out_axis,
  output logic             cur_src,
  output logic             switch_pending,
  output logic             stall_flag
);

  localparam int               CNT_W   = stall_cnt_w(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT - 1);

  sched_state_e                  state, state_nx;
  logic                          run;
  logic [CNT_W-1:0]              wd_cnt;

  logic                          cur_tvalid, cur_tuser, oth_tvalid, oth_tuser;
  logic [SVO_BITS_PER_PIXEL-1:0] cur_tdata;
  logic                          parked, accept, wd_hit;
  logic                          take_sof, take_force, take;
  logic                          cur_tready, oth_tready, slice_valid;

  assign cur_tvalid = (cur_src == SRC_B) ? b_axis.tvalid : a_axis.tvalid;
  assign cur_tuser  = (cur_src == SRC_B) ? b_axis.tuser  : a_axis.tuser;
  assign cur_tdata  = (cur_src == SRC_B) ? b_axis.tdata  : a_axis.tdata;
  assign oth_tvalid = (cur_src == SRC_B) ? a_axis.tvalid : b_axis.tvalid;
  assign oth_tuser  = (cur_src == SRC_B) ? a_axis.tuser  : b_axis.tuser;

  assign parked     = oth_tvalid && oth_tuser;
  assign wd_hit     = (wd_cnt == CNT_MAX);
  assign take_sof   = (state == WAIT) && (sel != cur_src) && cur_tvalid && cur_tuser && parked;
  assign take_force = wd_hit && parked;
  assign take       = take_sof || take_force;

  // On a take cycle the active source's beat (normally its SOF) stays put.
  assign slice_valid = cur_tvalid && run && !take;
  assign cur_tready  = accept && run && !take;
  assign oth_tready  = run && !parked;

  assign a_axis.tready = (cur_src == SRC_A) ? cur_tready : oth_tready;
  assign b_axis.tready = (cur_src == SRC_B) ? cur_tready : oth_tready;

  svo_axis_reg #(
    .DATA_W (SVO_BITS_PER_PIXEL),
    .USER_W (1)
  ) u_out_reg (
    .clk     (clk),
    .resetn  (resetn),
    .s_valid (slice_valid),
    .s_ready (accept),
    .s_data  (cur_tdata),
    .s_user  (cur_tuser),
    .m_valid (out_axis.tvalid),
    .m_ready (out_axis.tready),
    .m_data  (out_axis.tdata),
    .m_user  (out_axis.tuser)
  );

  always_comb begin
    state_nx       = state;
    switch_pending = (state == WAIT);
    unique case (state)
      RUN:  if (!take && (sel != cur_src)) state_nx = WAIT;
      WAIT: if (take || (sel == cur_src)) state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= RUN;
      run        <= 1'b0;
      cur_src    <= DEFAULT_SRC;
      wd_cnt     <= '0;
      stall_flag <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
      if (take) cur_src <= !cur_src;

      // Saturates at the limit so a late-parking source still triggers fallback.
      if (take || (cur_tvalid && cur_tready))
        wd_cnt <= '0;
      else if (run && accept && !cur_tvalid && !wd_hit)
        wd_cnt <= wd_cnt + CNT_W'(1);

      if (take_force)       stall_flag <= 1'b1;
      else if (stall_clear) stall_flag <= 1'b0;
    end
  end

endmodule

// File: doc/svo_src_sched.md
Name: svo_src_sched

Overview:
Frame-synchronous scheduler that shares the pixel-input stream of the HDMI overlay/encoder chain between two video sources: A (camera framebuffer) and B (test card).
- Switches only on start-of-frame (SOF) boundaries, so the selected source changes without tearing.
- The idle source is drained and parked at its next SOF.
- A stall watchdog falls back to the other source if the active one stops delivering.
- Sits in the clk_pixel domain, directly upstream of the overlay input stream.

Parameters:
SVO_BITS_PER_PIXEL, 12, pixel tdata width
STALL_LIMIT, 1024, consecutive starved cycles before a forced fallback (minimum 2)
DEFAULT_SRC, 0, source selected after reset (0 = A, 1 = B)

Ports:
clk  in  1  pixel clock
resetn  in  1  synchronous reset, active low
sel  in  1  requested source (0 = A, 1 = B); level, sampled every cycle
stall_clear  in  1  one-cycle pulse; clears stall_flag
a_axis_tvalid / a_axis_tready  in / out  1 / 1  source A handshake
a_axis_tdata  in  SVO_BITS_PER_PIXEL  source A pixel
a_axis_tuser  in  1  source A SOF marker
b_axis_tvalid / b_axis_tready / b_axis_tdata / b_axis_tuser  same widths as A; source B
out_axis_tvalid  out  1  output valid
out_axis_tready  in  1  output ready
out_axis_tdata  out  SVO_BITS_PER_PIXEL  output pixel
out_axis_tuser  out  1  output SOF marker
cur_src  out  1  source currently forwarded
switch_pending  out  1  switch requested, not yet taken
stall_flag  out  1  sticky; set when the watchdog forced a fallback

Behaviour:
Clocking and reset
- One clock, clk. Reset is synchronous and active-low on resetn.
- Reset values: cur_src = DEFAULT_SRC; out_axis_tvalid = 0; out_axis_tdata and out_axis_tuser = 0; switch_pending = 0; stall_flag = 0; watchdog counter = 0; FSM = RUN.
- An internal registered run bit is 0 in reset and 1 from the first cycle after reset is released. All *_tready outputs are forced to 0 while run = 0.

Output stage (sub-module)
- Single register slice, latency 1 cycle.
- accept = !out_axis_tvalid || out_axis_tready.
- Data is held stable while out_axis_tvalid = 1 and out_axis_tready = 0.

Active source (cur)
- cur_tready = accept && run, except that a SOF beat is blocked while a switch is being taken (see TAKE).
- Each accepted beat is copied into the output stage unmodified.

Idle source (oth), parking
- oth_tready = run && !(oth_tvalid && oth_tuser). Non-SOF beats are discarded.
- parked = oth_tvalid && oth_tuser (holding at SOF, not consumed).

FSM
- RUN: if sel != cur_src, go to WAIT and set switch_pending = 1.
- WAIT: if sel returns to cur_src, go to RUN and clear switch_pending.
  - Otherwise, when cur_tvalid && cur_tuser (active source at SOF) && parked, perform TAKE in that same cycle:
  - cur_tready = 0 for that cycle.
  - cur_src toggles.
  - switch_pending = 0.
  - Go to RUN.
- From the next cycle the new source's parked SOF beat is the first beat forwarded. The old source, now idle, is already parked at SOF.

Watchdog
- Counter increments when run && accept && !cur_tvalid; it resets to 0 on any accepted cur beat and on any switch.
- On reaching STALL_LIMIT-1 with parked = 1: forced TAKE regardless of cur SOF; set stall_flag; counter = 0; switch_pending = 0.
- After a forced TAKE the old source is drained to its next SOF. The output frame is truncated; downstream resyncs on tuser.
- At the limit with parked = 0: the counter saturates and the forced TAKE fires when parked becomes 1.

Simultaneous events and corner cases
- stall_clear and a flag set in the same cycle: the set wins.
- sel toggling within a frame has no visible effect unless it is still != cur_src at the SOF TAKE condition.
- A forced fallback while sel still requests the dead source leaves sel != cur_src, so the FSM enters WAIT and switches back at the next clean SOF pair.
- Reset mid-frame: the output stage is emptied (out_axis_tvalid = 0) and any partial frame is dropped. Both sources then re-park per the rules above.

Decomposition:
- Shared svo_defines package: source-ID constants SRC_A = 0 and SRC_B = 1, FSM state encodings RUN and WAIT, and a localparam computing the watchdog counter width as clog2(STALL_LIMIT).
- One sub-module, svo_axis_reg: generic registered AXI-stream slice, parameterised by data plus tuser width. It is reused for the output stage.

Test Plan:
- Reset, DEFAULT_SRC=0, A streams a 4-pixel frame (SOF on beat 0, data 0x001..0x004) with out_axis_tready=1 -> out_axis_tdata 0x001..0x004 one cycle after each A beat, tuser only on the first; B tready=1 until B presents SOF, then 0.
- sel 0->1 mid A-frame, B parked with SOF 0xF00 -> switch_pending=1 until A presents SOF; that A SOF is not consumed; next output beat is 0xF00 with tuser=1; cur_src=1.
- sel 0->1->0 within one frame -> no switch; switch_pending falls with sel; output contiguous A pixels.
- A tvalid held 0 for STALL_LIMIT=8 cycles while B parked -> forced switch on cycle 8; stall_flag=1; next output is B's SOF; a stall_clear pulse then clears stall_flag.
- out_axis_tready held 0 for 5 cycles mid-frame -> output data and tvalid stable; no watchdog increment; no A beat lost.
- resetn asserted low mid-frame -> next cycle out_axis_tvalid=0 and all treadys 0; after release the first output is a SOF beat of source DEFAULT_SRC.
